// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive directions.
// Holds the transmitter state encoding, the minimum usable divisor and the
// line-level constants for an idle line and a start bit.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Smallest clocks-per-bit value the bit timing supports; smaller requests
    // are raised to this value when a frame is accepted.
    localparam int MIN_DIV = 2;

    // Line levels: the line rests high and a frame opens with a low start bit.
    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART. The divisor is captured when a frame
// starts, the counter then runs 0..D-1 while enabled and wraps.
// tick marks the final cycle of a bit period (count == D-1) and pre_tick the
// cycle before it (count == D-2), which lets a caller register an output
// that must be high exactly during the last cycle of a bit.
// D is expected to be at least 2 so the two markers never coincide.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_WDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                enable,
    input  logic [DIV_WDTH-1:0] div,
    output logic                tick,
    output logic                pre_tick
);

    logic [DIV_WDTH-1:0] div_q;
    logic [DIV_WDTH-1:0] count;

    // Capture the divisor and restart the count on load, otherwise count
    // through the bit period and wrap to zero on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_WDTH'(MIN_DIV);
            count <= '0;
        end else if (load) begin
            div_q <= div;
            count <= '0;
        end else if (enable) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + DIV_WDTH'(1);
            end
        end
    end

    assign tick     = (count == (div_q - DIV_WDTH'(1)));
    assign pre_tick = (count == (div_q - DIV_WDTH'(2)));

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter. Accepts one word per VALIDi/READYo handshake and
// sends it LSB-first on TXo as start bit, data bits, optional parity bit and
// one or two stop bits, each bit lasting max(DIVi, 2) clocks.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the
// last data bit (even parity, or odd when PARITY_ODD = 1). Without the macro
// there is no parity state and PARITY_ODD has no effect.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WDTH  = 8,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WDTH   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLKip,
    input  logic                 RSTni,
    input  logic [DIV_WDTH-1:0]  DIVi,
    input  logic [DATA_WDTH-1:0] DATAi,
    input  logic                 VALIDi,
    output logic                 READYo,
    output logic                 TXo,
    output logic                 BUSYo,
    output logic                 DONEo
);

    localparam int BIT_W = $clog2(DATA_WDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    // Reject configurations the frame logic was not built for.
    if (DATA_WDTH < 5 || DATA_WDTH > 9) begin : g_bad_data_wdth
        $error("uart_tx: DATA_WDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    tx_state_t            state;
    logic [DATA_WDTH-1:0] shift_q;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 transfer;
    logic                 tick;
    logic                 pre_tick;
    logic [DIV_WDTH-1:0]  div_clamped;

    assign transfer    = VALIDi && ready_q;
    assign div_clamped = (DIVi < DIV_WDTH'(MIN_DIV)) ? DIV_WDTH'(MIN_DIV) : DIVi;

    uart_baud_tick #(
        .DIV_WDTH (DIV_WDTH)
    ) u_baud (
        .clk      (CLKip),
        .rst_n    (RSTni),
        .load     (transfer),
        .enable   (state != TX_IDLE),
        .div      (div_clamped),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Parity of the whole word, taken at acceptance before any shifting.
    always_ff @(posedge CLKip or negedge RSTni) begin
        if (!RSTni) begin
            parity_q <= 1'b0;
        end else if (transfer) begin
            parity_q <= (^DATAi) ^ (PARITY_ODD != 0);
        end
    end
`endif

    // Frame sequencer: every output is a flop, so each bit is set up on the
    // edge that starts it; DONEo is raised one cycle ahead via pre_tick so it
    // sits on the final cycle of the last stop bit.
    always_ff @(posedge CLKip or negedge RSTni) begin
        if (!RSTni) begin
            state    <= TX_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= UART_IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                TX_IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    tx_q    <= UART_IDLE;
                    if (transfer) begin
                        state    <= TX_START;
                        shift_q  <= DATAi;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        tx_q     <= UART_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        state   <= TX_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_cnt <= '0;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= TX_PARITY;
                            tx_q  <= parity_q;
`else
                            state    <= TX_STOP;
                            tx_q     <= UART_IDLE;
                            stop_cnt <= 1'b0;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (tick) begin
                        state    <= TX_STOP;
                        tx_q     <= UART_IDLE;
                        stop_cnt <= 1'b0;
                    end
                end
`endif
                TX_STOP: begin
                    if (pre_tick && (stop_cnt == LAST_STOP)) begin
                        done_q <= 1'b1;
                    end
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state   <= TX_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= TX_IDLE;
                    tx_q    <= UART_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign READYo = ready_q;
    assign TXo    = tx_q;
    assign BUSYo  = busy_q;
    assign DONEo  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Frames are compared cycle by cycle against the
// expected line pattern: start bit low, data LSB-first, optional parity, then
// high stop bits, each D cycles long, with DONEo on the last frame cycle and
// READYo back one cycle later. Build with UART_TX_PARITY_EN to cover parity.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic        CLKip;
    logic        RSTni;
    logic [15:0] DIVi;
    logic [7:0]  DATAi;
    logic        VALIDi;
    logic        valid2;
    logic        valid3;

    logic ready1, tx1, busy1, done1;
    logic ready2, tx2, busy2, done2;
    logic ready3, tx3, busy3, done3;

    int checks = 0;
    int errors = 0;

    uart_tx #(.DATA_WDTH(8), .STOP_BITS(1), .DIV_WDTH(16), .PARITY_ODD(0)) dut (
        .CLKip (CLKip), .RSTni (RSTni), .DIVi (DIVi), .DATAi (DATAi),
        .VALIDi (VALIDi), .READYo (ready1), .TXo (tx1), .BUSYo (busy1), .DONEo (done1)
    );

    uart_tx #(.DATA_WDTH(8), .STOP_BITS(2), .DIV_WDTH(16), .PARITY_ODD(0)) dut2 (
        .CLKip (CLKip), .RSTni (RSTni), .DIVi (DIVi), .DATAi (DATAi),
        .VALIDi (valid2), .READYo (ready2), .TXo (tx2), .BUSYo (busy2), .DONEo (done2)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx #(.DATA_WDTH(8), .STOP_BITS(1), .DIV_WDTH(16), .PARITY_ODD(1)) dut3 (
        .CLKip (CLKip), .RSTni (RSTni), .DIVi (DIVi), .DATAi (DATAi),
        .VALIDi (valid3), .READYo (ready3), .TXo (tx3), .BUSYo (busy3), .DONEo (done3)
    );
`else
    assign ready3 = 1'b0;
    assign tx3    = 1'b1;
    assign busy3  = 1'b0;
    assign done3  = 1'b0;
`endif

    initial CLKip = 1'b0;
    always #5 CLKip = ~CLKip;

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setValid(input int sel, input logic v);
        case (sel)
            1:       valid2 = v;
            2:       valid3 = v;
            default: VALIDi = v;
        endcase
    endtask

    // Present a word on the next falling edge; the caller then waits for the
    // rising edge on which it is accepted.
    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic [15:0] div);
        @(negedge CLKip);
        DATAi = data;
        DIVi  = div;
        setValid(sel, 1'b1);
    endtask

    // Called right after the accepting edge T; the k-th falling edge samples
    // cycle T+k. Inputs for whatever follows are applied at k = 1.
    task automatic watchFrame(input int sel, input string name, input logic [7:0] data,
                              input int d, input int stop_bits, input logic par,
                              input logic nv, input logic [7:0] ndata, input logic [15:0] ndiv);
        int len;
        int b;
        logic exp_tx;
        logic o_tx, o_ready, o_busy, o_done;
        len = (1 + 8 + P + stop_bits) * d;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge CLKip);
            if (k == 1) begin
                DATAi = ndata;
                DIVi  = ndiv;
                setValid(sel, nv);
            end
            b = (k - 1) / d;
            if (k > len)                 exp_tx = 1'b1;
            else if (b == 0)             exp_tx = 1'b0;
            else if (b <= 8)             exp_tx = data[b-1];
            else if (P == 1 && b == 9)   exp_tx = par;
            else                         exp_tx = 1'b1;
            case (sel)
                1:       begin o_tx = tx2; o_ready = ready2; o_busy = busy2; o_done = done2; end
                2:       begin o_tx = tx3; o_ready = ready3; o_busy = busy3; o_done = done3; end
                default: begin o_tx = tx1; o_ready = ready1; o_busy = busy1; o_done = done1; end
            endcase
            checkOutput($sformatf("%s tx T+%0d", name, k), 32'(o_tx), 32'(exp_tx));
            checkOutput($sformatf("%s ready T+%0d", name, k), 32'(o_ready), 32'(k > len));
            checkOutput($sformatf("%s busy T+%0d", name, k), 32'(o_busy), 32'(k <= len));
            checkOutput($sformatf("%s done T+%0d", name, k), 32'(o_done), 32'(k == len));
        end
    endtask

    // Drop reset just after a falling edge, check the outputs react with no
    // clock edge, hold it for a few cycles, then release and check recovery.
    task automatic pulseReset(input string name);
        #1 RSTni = 1'b0;
        #1;
        checkOutput({name, " tx async"},    32'(tx1),    32'd1);
        checkOutput({name, " busy async"},  32'(busy1),  32'd0);
        checkOutput({name, " ready async"}, 32'(ready1), 32'd0);
        checkOutput({name, " done async"},  32'(done1),  32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLKip);
            checkOutput($sformatf("%s done in reset %0d", name, k), 32'(done1), 32'd0);
            checkOutput($sformatf("%s tx in reset %0d", name, k), 32'(tx1), 32'd1);
            checkOutput($sformatf("%s ready in reset %0d", name, k), 32'(ready1), 32'd0);
        end
        RSTni = 1'b1;
        #1;
        checkOutput({name, " ready before edge"}, 32'(ready1), 32'd0);
        @(negedge CLKip);
        checkOutput({name, " ready after release"}, 32'(ready1), 32'd1);
        checkOutput({name, " busy after release"},  32'(busy1),  32'd0);
        checkOutput({name, " tx after release"},    32'(tx1),    32'd1);
        checkOutput({name, " done after release"},  32'(done1),  32'd0);
    endtask

    initial begin
        RSTni  = 1'b0;
        VALIDi = 1'b0;
        valid2 = 1'b0;
        valid3 = 1'b0;
        DIVi   = 16'd4;
        DATAi  = 8'h00;

        // Reset state and release
        @(negedge CLKip);
        @(negedge CLKip);
        checkOutput("reset tx",    32'(tx1),    32'd1);
        checkOutput("reset ready", 32'(ready1), 32'd0);
        checkOutput("reset busy",  32'(busy1),  32'd0);
        checkOutput("reset done",  32'(done1),  32'd0);
        RSTni = 1'b1;
        #1;
        checkOutput("ready before first edge", 32'(ready1), 32'd0);
        @(negedge CLKip);
        checkOutput("ready after release", 32'(ready1), 32'd1);
        checkOutput("ready2 after release", 32'(ready2), 32'd1);

        // Single frame: 0xA5 at 4 clocks per bit, DONEo at T+40
        applyStimulus(0, 8'hA5, 16'd4);
        @(posedge CLKip);
        watchFrame(0, "a5", 8'hA5, 4, 1, 1'b0, 1'b0, 8'h00, 16'd4);

        // Back-to-back with VALIDi held: 0x00 then 0xFF
        applyStimulus(0, 8'h00, 16'd4);
        @(posedge CLKip);
        watchFrame(0, "b2b00", 8'h00, 4, 1, 1'b0, 1'b1, 8'hFF, 16'd4);
        @(posedge CLKip);
        watchFrame(0, "b2bFF", 8'hFF, 4, 1, 1'b0, 1'b0, 8'h00, 16'd4);

        // Divisor 0 is raised to 2
        applyStimulus(0, 8'h55, 16'd0);
        @(posedge CLKip);
        watchFrame(0, "clamp", 8'h55, 2, 1, 1'b0, 1'b0, 8'h00, 16'd4);

        // Divisor change mid-frame only affects the following frame
        applyStimulus(0, 8'h3C, 16'd4);
        @(posedge CLKip);
        watchFrame(0, "div4", 8'h3C, 4, 1, 1'b0, 1'b1, 8'hC3, 16'd8);
        @(posedge CLKip);
        watchFrame(0, "div8", 8'hC3, 8, 1, 1'b0, 1'b0, 8'h00, 16'd4);

        // Two stop bits on the second instance: 0x81, D=3
        applyStimulus(1, 8'h81, 16'd3);
        @(posedge CLKip);
        watchFrame(1, "stop2", 8'h81, 3, 2, 1'b0, 1'b0, 8'h00, 16'd4);

        // Reset during data bit 3 (cycles T+17..T+20), sampled at T+18
        applyStimulus(0, 8'h00, 16'd4);
        @(posedge CLKip);
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLKip);
            if (k == 1) VALIDi = 1'b0;
        end
        checkOutput("midframe tx low", 32'(tx1),   32'd0);
        checkOutput("midframe busy",   32'(busy1), 32'd1);
        pulseReset("midframe");

        // All-ones divisor: start bit still low well past short wrap points
        applyStimulus(0, 8'hFF, 16'hFFFF);
        @(posedge CLKip);
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLKip);
            if (k == 1) VALIDi = 1'b0;
        end
        checkOutput("maxdiv start bit", 32'(tx1),   32'd0);
        checkOutput("maxdiv busy",      32'(busy1), 32'd1);
        checkOutput("maxdiv done",      32'(done1), 32'd0);
        pulseReset("maxdiv");

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; odd parity inverts both
        applyStimulus(0, 8'h07, 16'd4);
        @(posedge CLKip);
        watchFrame(0, "even07", 8'h07, 4, 1, 1'b1, 1'b0, 8'h00, 16'd4);
        applyStimulus(0, 8'h03, 16'd4);
        @(posedge CLKip);
        watchFrame(0, "even03", 8'h03, 4, 1, 1'b0, 1'b0, 8'h00, 16'd4);
        applyStimulus(2, 8'h07, 16'd4);
        @(posedge CLKip);
        watchFrame(2, "odd07", 8'h07, 4, 1, 1'b0, 1'b0, 8'h00, 16'd4);
        applyStimulus(2, 8'h03, 16'd4);
        @(posedge CLKip);
        watchFrame(2, "odd03", 8'h03, 4, 1, 1'b1, 1'b0, 8'h00, 16'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
